// File: rtl/conv_window_ctrl_if.sv
// Build-time defaults and the handshake bundle between the frame-config/stream
// source, the window controller and the line-buffer/MAC datapath.
package cfg_pkg;
    localparam string EXTEND_STRATEGY = "ZERO_PAD";
endpackage

interface conv_window_ctrl_if #(
    parameter int COL_W = 11,
    parameter int ROW_W = 11
);
    logic             cfg_vld;
    logic             cfg_rdy;
    logic [COL_W-1:0] cfg_width;
    logic [ROW_W-1:0] cfg_height;
    logic             in_vld;
    logic             in_rdy;
    logic             out_vld;
    logic             out_rdy;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic [8:0]       out_tap_mask;
    logic [5:0]       out_row_sel;
    logic [5:0]       out_col_sel;
    logic             out_sof;
    logic             out_eof;
    logic             busy;

    // Source/sink side: drives config, pixel valid and descriptor ready.
    modport master (
        output cfg_vld, cfg_width, cfg_height, in_vld, out_rdy,
        input  cfg_rdy, in_rdy, out_vld, out_row, out_col, out_tap_mask,
               out_row_sel, out_col_sel, out_sof, out_eof, busy
    );

    // Controller side.
    modport slave (
        input  cfg_vld, cfg_width, cfg_height, in_vld, out_rdy,
        output cfg_rdy, in_rdy, out_vld, out_row, out_col, out_tap_mask,
               out_row_sel, out_col_sel, out_sof, out_eof, busy
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// 3x3 window sequencer: paces the raster pixel stream so the line buffers
// always hold the rows a window needs, and emits one descriptor per output
// pixel with tap mask and edge-clamped tap selects.
module conv_window_ctrl #(
    parameter string EXTEND_STRATEGY = cfg_pkg::EXTEND_STRATEGY,
    parameter int    W_MAX           = 1024,
    parameter int    H_MAX           = 1024,
    parameter int    COL_W           = $clog2(W_MAX + 1),
    parameter int    ROW_W           = $clog2(H_MAX + 1)
) (
    input logic               clk,
    input logic               arst_n,
    conv_window_ctrl_if.slave bus
);
    localparam int LW  = COL_W + 2;
    localparam bit REP = (EXTEND_STRATEGY == "REPLICATE");

    localparam logic [COL_W-1:0] COL_ONE = 1;
    localparam logic [ROW_W-1:0] ROW_ONE = 1;
    localparam logic [LW-1:0]    LD_ONE  = 1;
    localparam logic [LW-1:0]    LD_TWO  = 2;

    generate
        if (EXTEND_STRATEGY != "ZERO_PAD" && EXTEND_STRATEGY != "REPLICATE") begin : g_bad_strategy
            $error("conv_window_ctrl: EXTEND_STRATEGY must be ZERO_PAD or REPLICATE");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] w_q, w_d, in_col_q, in_col_d, c_q, c_d;
    logic [ROW_W-1:0] h_q, h_d, in_row_q, in_row_d, r_q, r_d;
    logic [LW-1:0]    lead_q, lead_d;
    logic             in_done_q, in_done_d;

    logic             run, in_rdy, out_vld, in_acc, out_acc;
    logic [COL_W-1:0] w_m1;
    logic [ROW_W-1:0] h_m1;
    logic [LW-1:0]    need;
    logic [2:0]       row_out, col_out;
    logic [8:0]       mask;
    logic [5:0]       rsel, csel;

    // Handshake decode; depends on registered state only.
    always_comb begin
        run     = (state_q == RUN);
        w_m1    = w_q - COL_ONE;
        h_m1    = h_q - ROW_ONE;
        // A window needs the whole next row plus the pixel to its right.
        need    = ((r_q < h_m1) ? {2'b00, w_q} : '0) + ((c_q < w_m1) ? LD_ONE : '0) + LD_ONE;
        in_rdy  = run && !in_done_q && (lead_q < ({2'b00, w_q} + LD_TWO));
        out_vld = run && (in_done_q || (lead_q >= need));
        in_acc  = bus.in_vld && in_rdy;
        out_acc = out_vld && bus.out_rdy;
    end

    // Tap validity and row/column selects for the current centre.
    always_comb begin
        // Bit 0 = offset -1 out of frame, bit 2 = offset +1 out of frame.
        row_out = {r_q == h_m1, 1'b0, r_q == '0};
        col_out = {c_q == w_m1, 1'b0, c_q == '0};
        mask    = '0;
        rsel    = '0;
        csel    = '0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                mask[3*k+j] = REP ? 1'b1 : !(row_out[k] || col_out[j]);
            end
            rsel[2*k +: 2] = (REP && row_out[k]) ? 2'd1 : 2'(k);
            csel[2*k +: 2] = (REP && col_out[k]) ? 2'd1 : 2'(k);
        end
    end

    // Next-state: frame config in IDLE, pixel/window counters in RUN.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        c_d       = c_q;
        r_d       = r_q;
        lead_d    = lead_q;
        in_done_d = in_done_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_vld) begin
                    w_d       = (bus.cfg_width  == '0) ? COL_ONE : bus.cfg_width;
                    h_d       = (bus.cfg_height == '0) ? ROW_ONE : bus.cfg_height;
                    in_col_d  = '0;
                    in_row_d  = '0;
                    c_d       = '0;
                    r_d       = '0;
                    lead_d    = '0;
                    in_done_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (in_acc) begin
                    if (in_col_q == w_m1) begin
                        in_col_d = '0;
                        in_row_d = in_row_q + ROW_ONE;
                        if (in_row_q == h_m1) in_done_d = 1'b1;
                    end else begin
                        in_col_d = in_col_q + COL_ONE;
                    end
                end
                if (out_acc) begin
                    if (c_q == w_m1) begin
                        c_d = '0;
                        r_d = r_q + ROW_ONE;
                        if (r_q == h_m1) state_d = IDLE;
                    end else begin
                        c_d = c_q + COL_ONE;
                    end
                end
                if (in_acc && !out_acc)      lead_d = lead_q + LD_ONE;
                else if (!in_acc && out_acc) lead_d = lead_q - LD_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            w_q       <= '0;
            h_q       <= '0;
            in_col_q  <= '0;
            in_row_q  <= '0;
            c_q       <= '0;
            r_q       <= '0;
            lead_q    <= '0;
            in_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            h_q       <= h_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            c_q       <= c_d;
            r_q       <= r_d;
            lead_q    <= lead_d;
            in_done_q <= in_done_d;
        end
    end

    assign bus.cfg_rdy      = !run;
    assign bus.in_rdy       = in_rdy;
    assign bus.out_vld      = out_vld;
    assign bus.out_row      = r_q;
    assign bus.out_col      = c_q;
    assign bus.out_tap_mask = mask;
    assign bus.out_row_sel  = rsel;
    assign bus.out_col_sel  = csel;
    assign bus.out_sof      = (r_q == '0) && (c_q == '0);
    assign bus.out_eof      = (r_q == h_m1) && (c_q == w_m1);
    assign bus.busy         = run;
endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencing controller for the convolution datapath. Accepts a per-frame geometry, paces the raster pixel stream into the line-buffer datapath, and emits one 3x3 kernel-window descriptor per output pixel. Each descriptor carries the centre coordinate, a per-tap validity mask and clamped row/column tap selects, implementing the build-time kernel extension strategy. Sits between the frame-config/stream source and the line-buffer/MAC datapath; pixel data does not pass through this block.

## Interface
- EXTEND_STRATEGY, cfg_pkg::EXTEND_STRATEGY: "ZERO_PAD" or "REPLICATE"; any other value is an elaboration error.
- W_MAX, 1024: maximum frame width.
- H_MAX, 1024: maximum frame height.
- COL_W, $clog2(W_MAX+1): width of column quantities.
- ROW_W, $clog2(H_MAX+1): width of row quantities.

- clk  in  1  sole clock.
- arst_n  in  1  asynchronous, active-low reset.
- cfg_vld / cfg_rdy  in / out  1 / 1  frame-config handshake.
- cfg_width  in  COL_W  frame width W, 1..W_MAX.
- cfg_height  in  ROW_W  frame height H, 1..H_MAX.
- in_vld / in_rdy  in / out  1 / 1  pixel-accept handshake, raster order.
- out_vld / out_rdy  out / in  1 / 1  window-descriptor handshake.
- out_row  out  ROW_W  centre row r.
- out_col  out  COL_W  centre column c.
- out_tap_mask  out  9  bit k = 3*dy+dx; 1 = tap contributes.
- out_row_sel  out  6  field [2*dy+:2]: row offset 0/1/2 = -1/0/+1.
- out_col_sel  out  6  field [2*dx+:2]: column offset, same encoding.
- out_sof / out_eof  out  1 / 1  first / last window of the frame.
- busy  out  1  frame in progress.

## Operation
- States: IDLE and RUN.
- IDLE:
  - cfg_rdy=1.
  - On cfg_vld, latch W and H. A value of 0 is clamped to 1.
  - Clear all counters, then go to RUN.
- RUN:
  - cfg_rdy=0; cfg_vld is ignored.
  - Counters: in_row/in_col for accepted pixels; r/c for accepted windows; lead = pixels accepted minus windows accepted (COL_W+2 bits).
  - A simultaneous in-accept and out-accept leaves lead unchanged.
- in_rdy = RUN and not in_done and lead < W+2.
  - in_done sets when pixel (H-1,W-1) is accepted.
- Window (r,c) requires a lead of need = (r<H-1 ? W : 0) + (c<W-1 ? 1 : 0) + 1.
- out_vld = RUN and (in_done or lead >= need).
- Windows advance in raster order: c wraps to 0 at W-1, and r increments on wrap.
- On accepting window (H-1,W-1), go to IDLE.
- Tap (dy,dx) is out-of-frame when any of these holds:
  - r=0 and dy=0;
  - r=H-1 and dy=2;
  - c=0 and dx=0;
  - c=W-1 and dx=2.
  - H=1 or W=1 makes both edges apply.
- ZERO_PAD: mask bit is 0 for out-of-frame taps. Selects are identity: row_sel=col_sel=6'h24.
- REPLICATE: mask is always 9'h1FF. Any out-of-range offset field is clamped to 1 (centre).
- out_sof = (r=0 and c=0). out_eof = (r=H-1 and c=W-1).
- busy = (state==RUN).
- Descriptor outputs hold stable while out_vld=1 and out_rdy=0.

## Timing
- Reset values:
  - state IDLE, all counters 0, in_done 0.
  - cfg_rdy=1, in_rdy=0, out_vld=0, busy=0, out_sof=1, out_eof=0.
  - out_row=0, out_col=0.
  - out_tap_mask, out_row_sel, out_col_sel take the values the Operation rules give for (r,c)=(0,0) with W=H=0.
- All outputs decode from registered state only; there is no combinational path from input to output.
- Config accepted in cycle t: busy=1 and in_rdy=1 in cycle t+1.
- Pixel accept that satisfies need in cycle t: out_vld=1 in cycle t+1.
- Throughput: one pixel and one window per cycle, sustained.
- Last window accepted in cycle t: IDLE with cfg_rdy=1 in cycle t+1. The minimum gap between frames is one cycle.
- Reset asserted mid-frame: the frame is abandoned and all outputs return to reset values asynchronously.

## Test plan
- ZERO_PAD, W=4, H=3, in_vld=1, out_rdy=1:
  - first out_vld the cycle after the 6th pixel is accepted;
  - window (0,0): mask 9'h1B0, sof=1;
  - window (1,1): mask 9'h1FF;
  - 12 windows in total; eof on (2,3) with mask 9'h01B.
- REPLICATE, W=1, H=1:
  - one pixel, then one window: mask 9'h1FF, row_sel=col_sel=6'h15, sof=eof=1;
  - IDLE the next cycle.
- W=4, H=3 with out_rdy=0: in_rdy drops after exactly 6 accepts; releasing out_rdy resumes flow with no lost or duplicated windows.
- Random in_vld/out_rdy, 8x5, both strategies: descriptor sequence matches a raster reference model; outputs stable under stall.
- cfg_vld held high throughout a frame: cfg_rdy=0 while busy; the second config is taken exactly one cycle after eof.
- arst_n pulsed after 7 windows of a 4x3 frame: all outputs return to reset values; a new 2x2 frame then completes correctly.
